serial_div3: RTL and testbench

SERIAL_DIV3 -- requirements
Module: serial_div3

---
 rtl/div3_pkg.sv | 24 ++
 rtl/serial_div3.sv | 96 +++++++++
 tb/tb_serial_div3.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/div3_pkg.sv
// Shared types and helpers for the serial divide-by-3 checker.
package div3_pkg;

  // Running remainder of the bits seen so far, modulo 3.
  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2
  } rem_t;

  // Shift in one bit MSB-first: next = (2*r + b) mod 3.
  function automatic rem_t next_rem(input rem_t r, input logic b);
    rem_t n;
    n = R0;
    case (r)
      R0:      n = b ? R1 : R0;
      R1:      n = b ? R0 : R2;
      R2:      n = b ? R2 : R1;
      default: n = R0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/serial_div3.sv
// Serial MSB-first divisibility-by-3 checker with a one-deep result register.
module serial_div3
  import div3_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       bit_sof,
  output logic       bit_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_div,
  output logic [1:0] res_rem,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  rem_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_div_q, res_div_d;
  logic [1:0]       res_rem_q, res_rem_d;
  logic             frame_err_q, frame_err_d;

  logic             accept;
  logic [CNT_W-1:0] idx;
  rem_t             base;
  rem_t             step;

  // Stall upstream only while a result is held and not being taken.
  assign bit_ready = ~(res_valid_q & ~res_ready);
  assign accept    = bit_valid & bit_ready;

  // An sof bit always restarts the word at position 0 from R0.
  assign idx  = bit_sof ? '0 : cnt_q;
  assign base = (idx == '0) ? R0 : state_q;
  assign step = next_rem(base, bit_in);

  // State, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= R0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_div_q   <= 1'b0;
      res_rem_q   <= 2'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_div_q   <= res_div_d;
      res_rem_q   <= res_rem_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state: step the remainder FSM, count bits, publish on the last bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_div_d   = res_div_q;
    res_rem_d   = res_rem_q;
    frame_err_d = 1'b0;

    if (res_valid_q & res_ready) begin
      res_valid_d = 1'b0;
    end

    if (accept) begin
      frame_err_d = bit_sof & (cnt_q != '0);
      if (idx == LAST_IDX) begin
        res_valid_d = 1'b1;
        res_rem_d   = 2'(step);
        res_div_d   = (step == R0);
        state_d     = R0;
        cnt_d       = '0;
      end else begin
        state_d = step;
        cnt_d   = idx + CNT_W'(1);
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_div   = res_div_q;
  assign res_rem   = res_rem_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_div3.sv
// Directed and randomized-gap checks for serial_div3 (DATA_W = 8).
module tb_serial_div3;

  logic       clk;
  logic       rst;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_sof;
  logic       bit_ready;
  logic       res_valid;
  logic       res_ready;
  logic       res_div;
  logic [1:0] res_rem;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  logic rdy_low = 1'b0;

  serial_div3 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_sof   (bit_sof),
    .bit_ready (bit_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_div   (res_div),
    .res_rem   (res_rem),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one bit, let one edge pass, return at edge+1.
  task automatic send_bit(input logic b, input logic sof);
    bit_valid = 1'b1;
    bit_in    = b;
    bit_sof   = sof;
    #1;
    if (!bit_ready) rdy_low = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_sof   = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], i == 7);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] cur;
    int         bitpos;
    int         sent;
    int         results;
    int         cyc;
    int         expq[$];
    int         e;

    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_sof = 1'b0; res_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_div",   res_div,   0);
    chk("rst_rem",   res_rem,   0);
    chk("rst_ferr",  frame_err, 0);
    chk("rst_ready", bit_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Back-to-back 0 and 255, both divisible
    rdy_low = 1'b0;
    send_word(8'd0);
    chk("w0_valid", res_valid, 1);
    chk("w0_div",   res_div,   1);
    chk("w0_rem",   res_rem,   0);
    send_word(8'd255);
    chk("w255_valid", res_valid, 1);
    chk("w255_div",   res_div,   1);
    chk("w255_rem",   res_rem,   0);
    chk("b2b_ready_never_low", rdy_low, 0);

    // 7 with an sof-without-valid cycle mid-word, then 200
    w = 8'd7;
    for (int i = 7; i >= 5; i--) send_bit(w[i], i == 7);
    bit_sof = 1'b1;
    @(posedge clk); #1;
    bit_sof = 1'b0;
    chk("sof_novalid_ferr", frame_err, 0);
    for (int i = 4; i >= 0; i--) send_bit(w[i], 1'b0);
    chk("w7_valid", res_valid, 1);
    chk("w7_div",   res_div,   0);
    chk("w7_rem",   res_rem,   1);
    send_word(8'd200);
    chk("w200_valid", res_valid, 1);
    chk("w200_div",   res_div,   0);
    chk("w200_rem",   res_rem,   2);
    idle(1);
    chk("w200_consumed", res_valid, 0);

    // 9 with downstream stalled for 3 cycles
    res_ready = 1'b0;
    send_word(8'd9);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_div",   res_div,   1);
      chk("stall_rem",   res_rem,   0);
      chk("stall_ready", bit_ready, 0);
      idle(1);
    end
    res_ready = 1'b1;
    #1;
    chk("release_ready_comb", bit_ready, 1);
    @(posedge clk); #1;
    chk("release_valid", res_valid, 0);
    chk("release_ready", bit_ready, 1);

    // Abort after 3 bits with an early sof, then full 9
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("pre_abort_ferr", frame_err, 0);
    w = 8'd9;
    send_bit(w[7], 1'b1);
    chk("abort_ferr", frame_err, 1);
    chk("abort_valid", res_valid, 0);
    send_bit(w[6], 1'b0);
    chk("abort_ferr_pulse", frame_err, 0);
    for (int i = 5; i >= 1; i--) begin
      send_bit(w[i], 1'b0);
      chk("abort_no_result", res_valid, 0);
    end
    send_bit(w[0], 1'b0);
    chk("w9b_valid", res_valid, 1);
    chk("w9b_div",   res_div,   1);
    chk("w9b_rem",   res_rem,   0);

    // Reset mid-word, then 4
    send_word(8'd200);
    chk("pre_rst_rem", res_rem, 2);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("mid_valid", res_valid, 0);
    chk("mid_rem_held", res_rem, 2);
    rst = 1'b1;
    #1;
    chk("async_rst_rem",   res_rem,   0);
    chk("async_rst_div",   res_div,   0);
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_ferr",  frame_err, 0);
    chk("async_rst_ready", bit_ready, 1);
    @(posedge clk); #1;
    chk("in_rst_ready", bit_ready, 1);
    rst = 1'b0;
    send_word(8'd4);
    chk("w4_valid", res_valid, 1);
    chk("w4_div",   res_div,   0);
    chk("w4_rem",   res_rem,   1);
    idle(1);

    // All 256 values with random input and output gaps
    cur = 8'd0; bitpos = 7; sent = 0; results = 0; cyc = 0;
    while ((sent < 256 || expq.size() != 0 || res_valid) && cyc < 20000) begin
      bit_valid = (sent < 256) && ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0) || (sent >= 256);
      bit_in    = bit_valid ? cur[bitpos] : 1'b0;
      bit_sof   = bit_valid && (bitpos == 7);
      #1;
      if (res_valid && res_ready) begin
        chk("rnd_pending", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("rnd_rem", res_rem, e);
          chk("rnd_div", res_div, e == 0);
          results++;
        end
      end
      if (bit_valid && bit_ready) begin
        if (bitpos == 0) begin
          expq.push_back(int'(cur) % 3);
          sent++;
          cur = cur + 8'd1;
          bitpos = 7;
        end else begin
          bitpos--;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bit_valid = 1'b0; bit_sof = 1'b0; bit_in = 1'b0; res_ready = 1'b1;
    chk("rnd_in_time", cyc < 20000, 1);
    chk("rnd_count", results, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
